// File: rtl/safety_pkg.sv
// safety_pkg: shared state encoding and counter sizing for the safety enable sequencer.
package safety_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        RUN    = 2'd2,
        FAULT  = 2'd3
    } safety_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: asserts after DEBOUNCE_CYCLES consecutive high inputs, drops on the first low.
module debounce_filter
    import safety_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din_s,
    output logic dout_db
);

    localparam int W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [W-1:0] MAX = W'(DEBOUNCE_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!din_s)
            cnt <= '0;
        else if (cnt != MAX)
            cnt <= cnt + 1'b1;
    end

    assign dout_db = (cnt == MAX);

endmodule

// File: rtl/safety_enable_sequencer.sv
// safety_enable_sequencer: conditions operator buttons and runs the IDLE/ARMING/RUN/FAULT
// safety FSM that drives the motor enable.
module safety_enable_sequencer
    import safety_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int ARM_HOLD_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       estop_btn,
    input  logic       fault_clear_btn,
    input  logic       ext_fault,
    output logic       motor_enable,
    output logic [1:0] state,
    output logic       fault_latched
);

    localparam int AW = cnt_width(ARM_HOLD_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_HOLD_CYCLES - 1);

    logic [3:0] sync1, sync2;
    logic start_s, stop_s, estop_s, clear_s;
    logic start_db, stop_db, clear_db, estop_rel_db, estop_db;
    logic start_q, clear_q, start_ok, start_rise, clear_rise, flt;
    logic [1:0] prime;
    logic [AW-1:0] arm;
    safety_state_t st;

    assign {start_s, stop_s, estop_s, clear_s} = sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {start_btn, stop_btn, estop_btn, fault_clear_btn};
            sync2 <= sync1;
        end
    end

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock(clock), .reset_n(reset_n), .din_s(start_s), .dout_db(start_db));
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clock(clock), .reset_n(reset_n), .din_s(stop_s), .dout_db(stop_db));
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock(clock), .reset_n(reset_n), .din_s(clear_s), .dout_db(clear_db));
    // E-stop trips instantly from estop_s; only its release is filtered.
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_estop (
        .clock(clock), .reset_n(reset_n), .din_s(!estop_s), .dout_db(estop_rel_db));

    assign estop_db = !estop_rel_db;

    // start_ok blocks arming until start has been seen released through a primed synchroniser,
    // so a button held across reset never produces a start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            prime    <= '0;
            start_ok <= 1'b0;
        end else begin
            start_q  <= start_db;
            clear_q  <= clear_db;
            prime    <= {prime[0], 1'b1};
            start_ok <= start_ok | (prime[1] & !start_s);
        end
    end

    assign start_rise = start_db && !start_q && start_ok;
    assign clear_rise = clear_db && !clear_q;
    assign flt        = estop_s || ext_fault;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st  <= IDLE;
            arm <= '0;
        end else if (flt) begin
            st <= FAULT;
        end else begin
            unique case (st)
                IDLE: if (start_rise && !stop_db) begin
                    st  <= ARMING;
                    arm <= '0;
                end
                ARMING: if (stop_db || !start_db)
                    st <= IDLE;
                else if (arm == ARM_LAST)
                    st <= RUN;
                else
                    arm <= arm + 1'b1;
                RUN: if (stop_db)
                    st <= IDLE;
                FAULT: if (!estop_db && !estop_s && !ext_fault && clear_rise)
                    st <= IDLE;
            endcase
        end
    end

    assign state         = st;
    assign motor_enable  = (st == RUN);
    assign fault_latched = (st == FAULT);

endmodule

// File: tb/tb_safety_enable_sequencer.sv
// tb_safety_enable_sequencer: directed test-plan steps plus random button traffic,
// compared each cycle against a behavioural model built on run lengths and a delay queue.
module tb_safety_enable_sequencer;

    localparam int DC = 4;
    localparam int AH = 8;

    logic clock = 1'b0;
    logic reset_n;
    logic start_btn, stop_btn, estop_btn, fault_clear_btn, ext_fault;
    logic motor_enable, fault_latched;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    safety_enable_sequencer #(.DEBOUNCE_CYCLES(DC), .ARM_HOLD_CYCLES(AH)) dut (
        .clock(clock), .reset_n(reset_n), .start_btn(start_btn), .stop_btn(stop_btn),
        .estop_btn(estop_btn), .fault_clear_btn(fault_clear_btn), .ext_fault(ext_fault),
        .motor_enable(motor_enable), .state(state), .fault_latched(fault_latched));

    always #5 clock = ~clock;

    // Model: ms 0 idle, 1 arming, 2 run, 3 fault; sync is a two-deep queue of raw samples,
    // conditioned buttons are run lengths of consecutive synchronised highs (or lows for e-stop).
    int ms, marm, run_st, run_sp, run_cl, run_rel, since;
    bit pdb_st, pdb_cl, ok;
    logic [3:0] pipe[$];

    task automatic m_reset();
        ms = 0; marm = 0; run_st = 0; run_sp = 0; run_cl = 0; run_rel = 0; since = 0;
        pdb_st = 0; pdb_cl = 0; ok = 0;
        pipe = {4'b0000, 4'b0000};
    endtask

    function automatic int sat(input bit s, input int r);
        return s ? ((r < DC) ? r + 1 : r) : 0;
    endfunction

    task automatic m_edge(input logic [3:0] raw, input bit ext);
        logic [3:0] s;
        bit st_db, sp_db, cl_db, es_db, st_rise, cl_rise;
        s       = pipe[0];
        st_db   = run_st >= DC;
        sp_db   = run_sp >= DC;
        cl_db   = run_cl >= DC;
        es_db   = run_rel < DC;
        st_rise = st_db && !pdb_st && ok;
        cl_rise = cl_db && !pdb_cl;
        if (s[1] || ext) ms = 3;
        else if (ms == 0) begin
            if (st_rise && !sp_db) begin ms = 1; marm = 0; end
        end else if (ms == 1) begin
            if (sp_db || !st_db) ms = 0;
            else if (marm == AH - 1) ms = 2;
            else marm++;
        end else if (ms == 2) begin
            if (sp_db) ms = 0;
        end else if (!es_db && !s[1] && !ext && cl_rise) ms = 0;
        pdb_st  = st_db;
        pdb_cl  = cl_db;
        run_st  = sat(s[3], run_st);
        run_sp  = sat(s[2], run_sp);
        run_cl  = sat(s[0], run_cl);
        run_rel = sat(!s[1], run_rel);
        if (since >= 2 && !s[3]) ok = 1;
        if (since < 10) since++;
        pipe.push_back(raw);
        void'(pipe.pop_front());
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        m_edge({start_btn, stop_btn, estop_btn, fault_clear_btn}, ext_fault);
        @(negedge clock);
        chk("state", state, 2'(ms));
        chk("motor_enable", {1'b0, motor_enable}, 2'(ms == 2));
        chk("fault_latched", {1'b0, fault_latched}, 2'(ms == 3));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_motor", {1'b0, motor_enable}, 2'd0);
        chk("rst_state", state, 2'd0);
        chk("rst_fault", {1'b0, fault_latched}, 2'd0);
        m_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic arm_to_run();
        start_btn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 6) chk("arm_not_yet", state, 2'd0);
            if (i == 7) chk("arm_at7", state, 2'd1);
            if (i == 14) chk("run_not_yet", state, 2'd1);
            if (i == 15) chk("run_at15", state, 2'd2);
        end
    endtask

    task automatic clear_fault();
        fault_clear_btn = 1'b1;
        run(8);
        chk("cleared_idle", state, 2'd0);
        fault_clear_btn = 1'b0;
        run(4);
    endtask

    logic [3:0] rb;
    int tmr[4];

    initial begin
        reset_n = 1'b0;
        {start_btn, stop_btn, estop_btn, fault_clear_btn, ext_fault} = '0;
        m_reset();
        repeat (3) @(negedge clock);
        chk("reset_state", state, 2'd0);
        chk("reset_motor", {1'b0, motor_enable}, 2'd0);
        chk("reset_fault", {1'b0, fault_latched}, 2'd0);
        reset_n = 1'b1;
        run(5);

        // 1: arm and run
        arm_to_run();
        run(4);
        start_btn = 1'b0;
        run(6);
        chk("run_holds", state, 2'd2);

        // 2: stop bounce then hold
        for (int i = 0; i < 6; i++) begin
            stop_btn = (i % 2 == 0);
            step();
            chk("bounce_run", state, 2'd2);
        end
        stop_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) chk("stop_not_yet", state, 2'd2);
            if (i == 7) chk("stop_idle7", state, 2'd0);
        end
        chk("stop_motor", {1'b0, motor_enable}, 2'd0);
        stop_btn = 1'b0;
        run(5);

        // 3: single-cycle e-stop pulse in RUN
        arm_to_run();
        start_btn = 1'b0;
        run(3);
        estop_btn = 1'b1;
        step();
        estop_btn = 1'b0;
        step();
        chk("estop_edge2", state, 2'd2);
        step();
        chk("estop_edge3", state, 2'd3);
        chk("estop_motor", {1'b0, motor_enable}, 2'd0);
        chk("estop_latched", {1'b0, fault_latched}, 2'd1);

        // 4: clear ignored while e-stop held, accepted after release
        estop_btn = 1'b1;
        run(5);
        fault_clear_btn = 1'b1;
        run(8);
        chk("clear_ignored", state, 2'd3);
        fault_clear_btn = 1'b0;
        run(3);
        estop_btn = 1'b0;
        run(10);
        chk("still_fault", state, 2'd3);
        clear_fault();

        // 5: async reset mid-RUN with start held
        arm_to_run();
        async_reset_pulse();
        run(20);
        chk("held_no_arm", state, 2'd0);
        start_btn = 1'b0;
        run(5);

        // 6a: start released early in ARMING
        start_btn = 1'b1;
        run(9);
        chk("arming_cnt2", state, 2'd1);
        start_btn = 1'b0;
        run(5);
        chk("early_release", state, 2'd0);
        run(5);

        // 6b: ext_fault during ARMING
        start_btn = 1'b1;
        run(9);
        chk("arming_ext", state, 2'd1);
        ext_fault = 1'b1;
        step();
        chk("ext_fault_next", state, 2'd3);
        ext_fault = 1'b0;
        start_btn = 1'b0;
        run(3);
        clear_fault();

        // start and stop together never arm
        {start_btn, stop_btn} = 2'b11;
        run(12);
        chk("start_stop_idle", state, 2'd0);
        {start_btn, stop_btn} = 2'b00;
        run(5);

        // random traffic
        rb = '0;
        for (int b = 0; b < 4; b++) tmr[b] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if (tmr[b] == 0) begin
                    case (b)
                        3: rb[b] = ($urandom_range(0, 1) == 0);
                        2: rb[b] = ($urandom_range(0, 5) == 0);
                        1: rb[b] = ($urandom_range(0, 9) == 0);
                        default: rb[b] = ($urandom_range(0, 1) == 0);
                    endcase
                    tmr[b] = $urandom_range(1, 30);
                end else tmr[b]--;
            end
            {start_btn, stop_btn, estop_btn, fault_clear_btn} = rb;
            ext_fault = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 399) == 0) async_reset_pulse();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
